image_scan_reader: RTL and testbench
====================================

Name: image_scan_reader

Overview:
- Upstream feeder for the image decimation stage.
- On a start pulse, walks a source image stored in single-port BRAM in row-major order (x fastest).
- Compensates for the BRAM read latency and streams each pixel with its (x, y) coordinates and a valid strobe, in the data/x/y/valid format the half-resolution stage consumes.
- Signals busy, done and misuse errors to the pyramid controller.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- WIDTH, 64, source image width in pixels, 1..256.
- HEIGHT, 64, source image height in pixels, 1..256.
- BRAM_LATENCY, 2, cycles from address driven to data on bram_data_in, 1..4.

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  single-cycle request to begin a scan.
- bram_addr_out  output  $clog2(WIDTH*HEIGHT)  BRAM read address, registered.
- bram_data_in  input  BIT_DEPTH  BRAM read data.
- data_out  output  BIT_DEPTH  pixel value, driven combinationally from bram_data_in.
- data_x_out  output  8  column of the current pixel.
- data_y_out  output  8  row of the current pixel.
- data_valid_out  output  1  data_out, data_x_out and data_y_out form a valid pixel this cycle.
- busy_out  output  1  scan in progress.
- done_out  output  1  one-cycle pulse when the last pixel has been emitted.
- error_out  output  1  one-cycle pulse when start_in is rejected.

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE.
  - bram_addr_out, data_x_out, data_y_out, data_valid_out, busy_out, done_out and error_out are all 0.
  - The x/y/valid delay pipeline is cleared.
- Reset mid-scan: outputs drop immediately, no done_out is produced, and the scan is not resumed.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_in high moves to READ at the next edge.
  - That same edge loads bram_addr_out=0 and the x and y counters with 0.
- READ, each cycle:
  - Present bram_addr_out = y*WIDTH + x.
  - Push (x, y, valid=1) into the delay pipeline, which is BRAM_LATENCY stages deep.
  - Advance x. When x=WIDTH-1, wrap x to 0 and increment y.
  - When the issued address is WIDTH*HEIGHT-1, move to DRAIN at the next edge.
- DRAIN:
  - Push valid=0 into the pipeline each cycle.
  - After BRAM_LATENCY cycles, move to DONE.
  - bram_addr_out holds its last value.
- DONE:
  - done_out=1 for exactly this one cycle, then return to IDLE.
  - start_in high in DONE is accepted exactly as in IDLE, with no error.
- Pipeline alignment:
  - The address issued in cycle t appears on data_out in cycle t+BRAM_LATENCY.
  - data_x_out, data_y_out and data_valid_out come from the final pipeline stage, so they align with that data.
  - When data_valid_out=0, data_x_out and data_y_out are 0.
- Timing:
  - data_valid_out is high for exactly WIDTH*HEIGHT consecutive cycles, with no gaps.
  - The first valid beat is in cycle 1+BRAM_LATENCY, counting the start cycle as cycle 0.
  - busy_out is high in READ and DRAIN only.
- start_in high during READ or DRAIN:
  - The request is ignored.
  - error_out pulses high for that cycle, registered so it is seen the following cycle.
  - The scan continues unaffected.
- Counter width:
  - x and y are 8-bit counters.
  - The address product uses full width; no truncation below $clog2(WIDTH*HEIGHT) bits.
- Degenerate sizes:
  - WIDTH=1: y increments every cycle.
  - WIDTH=HEIGHT=1: exactly one READ cycle, followed by DRAIN.

Test Plan:
- WIDTH=4, HEIGHT=4, BRAM_LATENCY=2, BRAM preloaded with mem[a]=a, start_in pulsed in cycle 0:
  - bram_addr_out reads 0..15 in cycles 1..16.
  - data_valid_out is high in cycles 3..18 with data_out=0..15.
  - (x, y) runs (0,0),(1,0),…,(3,0),(0,1),…,(3,3).
  - busy_out is high in cycles 1..18; done_out pulses in cycle 19.
- Same setup with start_in pulsed again in cycle 8:
  - error_out pulses once.
  - The stream is identical to the first scenario.
  - done_out still occurs in cycle 19.
- Same setup with rst_in driven low mid-cycle 10:
  - All outputs read 0 immediately.
  - No done_out is produced.
  - A fresh start_in afterwards reproduces the first scenario exactly.
- WIDTH=1, HEIGHT=1, BRAM_LATENCY=1, start in cycle 0:
  - One valid beat in cycle 2 with (0,0).
  - done_out pulses in cycle 3.
- Back-to-back: start_in asserted in the DONE cycle:
  - A second scan begins with no error.
  - 32 total valid beats.
  - Two done_out pulses.
- WIDTH=64, HEIGHT=64 feeding the half-resolution stage with NEW_HEIGHT=32:
  - Exactly 1024 output writes.
  - The last write is to address 1023 and carries the pixel at (62,62).

Source files
------------

// File: rtl/image_scan_reader.sv
// Raster-order BRAM scanner: walks the source image after a start pulse and streams
// each pixel with its (x, y) coordinates, aligned to the BRAM read latency.
module image_scan_reader #(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int BRAM_LATENCY = 2,
  localparam int ADDR_W      = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [ADDR_W-1:0]    bram_addr_out,
  input  logic [BIT_DEPTH-1:0] bram_data_in,
  output logic [BIT_DEPTH-1:0] data_out,
  output logic [7:0]           data_x_out,
  output logic [7:0]           data_y_out,
  output logic                 data_valid_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]        X_LAST     = 8'(WIDTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(BRAM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [1:0]        drain_q, drain_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        x_push_s;
  logic [7:0]        y_push_s;
  logic              vld_push_s;
  logic [7:0]        x_pipe_q   [BRAM_LATENCY];
  logic [7:0]        y_pipe_q   [BRAM_LATENCY];
  logic              vld_pipe_q [BRAM_LATENCY];

  // Scan sequencing: next state, address/coordinate counters and status flags
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    drain_d = drain_q;
    error_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = READ;
          addr_d  = {ADDR_W{1'b0}};
          x_d     = 8'd0;
          y_d     = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        error_d = start_in;
        if (addr_q == ADDR_LAST) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d = 8'd0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        error_d = start_in;
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Only READ cycles carry a real pixel tag; everything else pushes a zero bubble
  always_comb begin
    if (state_q == READ) begin
      x_push_s   = x_q;
      y_push_s   = y_q;
      vld_push_s = 1'b1;
    end else begin
      x_push_s   = 8'd0;
      y_push_s   = 8'd0;
      vld_push_s = 1'b0;
    end
  end

  // Control and status registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      drain_q <= 2'd0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Coordinate/valid delay line matching the BRAM read latency
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        x_pipe_q[i]   <= 8'd0;
        y_pipe_q[i]   <= 8'd0;
        vld_pipe_q[i] <= 1'b0;
      end
    end else begin
      x_pipe_q[0]   <= x_push_s;
      y_pipe_q[0]   <= y_push_s;
      vld_pipe_q[0] <= vld_push_s;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        x_pipe_q[i]   <= x_pipe_q[i-1];
        y_pipe_q[i]   <= y_pipe_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign bram_addr_out  = addr_q;
  assign data_out       = bram_data_in;
  assign data_x_out     = x_pipe_q[BRAM_LATENCY-1];
  assign data_y_out     = y_pipe_q[BRAM_LATENCY-1];
  assign data_valid_out = vld_pipe_q[BRAM_LATENCY-1];
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = error_q;

endmodule

// File: tb/tb_image_scan_reader.sv
// Bench for image_scan_reader: three configurations (4x4/L2, 1x1/L1, 64x64/L2) checked
// every cycle against a scan-position model, plus literal event timing checks.
module tb_image_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst12, start0, start1, start2;
  logic [3:0]  addr0;
  logic [0:0]  addr1;
  logic [11:0] addr2;
  logic [7:0]  bd0, bd1, bd2, d0, d1, d2, x0, x1, x2, y0, y1, y2;
  logic        v0, v1, v2, b0, b1, b2, dn0, dn1, dn2, e0, e1, e2;

  image_scan_reader #(.BIT_DEPTH(8), .WIDTH(4), .HEIGHT(4), .BRAM_LATENCY(2)) dut0 (
    .clk_in(clk), .rst_in(rst0), .start_in(start0), .bram_addr_out(addr0),
    .bram_data_in(bd0), .data_out(d0), .data_x_out(x0), .data_y_out(y0),
    .data_valid_out(v0), .busy_out(b0), .done_out(dn0), .error_out(e0));

  image_scan_reader #(.BIT_DEPTH(8), .WIDTH(1), .HEIGHT(1), .BRAM_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst12), .start_in(start1), .bram_addr_out(addr1),
    .bram_data_in(bd1), .data_out(d1), .data_x_out(x1), .data_y_out(y1),
    .data_valid_out(v1), .busy_out(b1), .done_out(dn1), .error_out(e1));

  image_scan_reader #(.BIT_DEPTH(8), .WIDTH(64), .HEIGHT(64), .BRAM_LATENCY(2)) dut2 (
    .clk_in(clk), .rst_in(rst12), .start_in(start2), .bram_addr_out(addr2),
    .bram_data_in(bd2), .data_out(d2), .data_x_out(x2), .data_y_out(y2),
    .data_valid_out(v2), .busy_out(b2), .done_out(dn2), .error_out(e2));

  function automatic logic [7:0] pixval(input int id, input int a);
    if (id == 0) return a[7:0];
    if (id == 1) return 8'hA5;
    return 8'((a * 37 + 5) % 256);
  endfunction

  // BRAM models with the configured read latency
  logic [7:0] p0a, p0b, p1a, p2a, p2b;
  always @(posedge clk) begin
    p0a <= pixval(0, int'(addr0));
    p0b <= p0a;
    p1a <= pixval(1, int'(addr1));
    p2a <= pixval(2, int'(addr2));
    p2b <= p2a;
  end
  assign bd0 = p0b;
  assign bd1 = p1a;
  assign bd2 = p2b;

  logic [15:0] addr_s [3];
  logic [7:0]  data_s [3], x_s [3], y_s [3];
  logic        valid_s [3], busy_s [3], done_s [3], err_s [3], start_s [3], rst_s [3];
  assign addr_s[0] = 16'(addr0);
  assign addr_s[1] = 16'(addr1);
  assign addr_s[2] = 16'(addr2);
  assign data_s[0] = d0;  assign data_s[1] = d1;  assign data_s[2] = d2;
  assign x_s[0] = x0;     assign x_s[1] = x1;     assign x_s[2] = x2;
  assign y_s[0] = y0;     assign y_s[1] = y1;     assign y_s[2] = y2;
  assign valid_s[0] = v0; assign valid_s[1] = v1; assign valid_s[2] = v2;
  assign busy_s[0] = b0;  assign busy_s[1] = b1;  assign busy_s[2] = b2;
  assign done_s[0] = dn0; assign done_s[1] = dn1; assign done_s[2] = dn2;
  assign err_s[0] = e0;   assign err_s[1] = e1;   assign err_s[2] = e2;
  assign start_s[0] = start0; assign start_s[1] = start1; assign start_s[2] = start2;
  assign rst_s[0] = rst0; assign rst_s[1] = rst12; assign rst_s[2] = rst12;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: k = cycles since the accepted start (-1 = no scan in flight)
  int NN [3] = '{16, 1, 4096};
  int WW [3] = '{4, 1, 64};
  int LL [3] = '{2, 1, 2};
  int k [3] = '{-1, -1, -1};
  int exp_addr [3] = '{0, 0, 0};
  bit err_pend [3] = '{1'b0, 1'b0, 1'b0};
  int valid_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int err_cnt [3] = '{0, 0, 0};
  int rise_cyc [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  bit prev_valid [3] = '{1'b0, 1'b0, 1'b0};
  int wr_cnt = 0, last_wr_addr = -1, last_wx = -1, last_wy = -1;
  int kk, n, l, w, p;
  bit ev;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_s[i]) begin
        chk($sformatf("d%0d_rst_addr", i), 32'(addr_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_x", i), 32'(x_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_y", i), 32'(y_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_valid", i), 32'(valid_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_busy", i), 32'(busy_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_done", i), 32'(done_s[i]), 32'd0);
        chk($sformatf("d%0d_rst_err", i), 32'(err_s[i]), 32'd0);
        k[i] = -1;
        exp_addr[i] = 0;
        err_pend[i] = 1'b0;
        prev_valid[i] = 1'b0;
      end else begin
        kk = k[i]; n = NN[i]; l = LL[i]; w = WW[i];
        if (kk >= 1 && kk <= n) exp_addr[i] = kk - 1;
        ev = (kk >= l + 1) && (kk <= l + n);
        p = kk - l - 1;
        chk($sformatf("d%0d_addr", i), 32'(addr_s[i]), 32'(exp_addr[i]));
        chk($sformatf("d%0d_busy", i), 32'(busy_s[i]), 32'(kk >= 1 && kk <= n + l));
        chk($sformatf("d%0d_done", i), 32'(done_s[i]), 32'(kk == n + l + 1));
        chk($sformatf("d%0d_valid", i), 32'(valid_s[i]), 32'(ev));
        chk($sformatf("d%0d_err", i), 32'(err_s[i]), 32'(err_pend[i]));
        if (ev) begin
          chk($sformatf("d%0d_data", i), 32'(data_s[i]), 32'(pixval(i, p)));
          chk($sformatf("d%0d_x", i), 32'(x_s[i]), 32'(p % w));
          chk($sformatf("d%0d_y", i), 32'(y_s[i]), 32'(p / w));
        end else begin
          chk($sformatf("d%0d_x_idle", i), 32'(x_s[i]), 32'd0);
          chk($sformatf("d%0d_y_idle", i), 32'(y_s[i]), 32'd0);
        end
        err_pend[i] = start_s[i] && kk >= 1 && kk <= n + l;
        if (start_s[i] && (kk < 0 || kk == n + l + 1)) k[i] = 1;
        else if (kk >= 1 && kk < n + l + 1) k[i] = kk + 1;
        else if (kk == n + l + 1) k[i] = -1;
        if (valid_s[i]) begin
          valid_cnt[i]++;
          if (!prev_valid[i]) rise_cyc[i] = cyc;
        end
        prev_valid[i] = valid_s[i];
        if (done_s[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (err_s[i]) err_cnt[i]++;
        if (i == 2 && valid_s[2] && !x_s[2][0] && !y_s[2][0]) begin
          wr_cnt++;
          last_wr_addr = (int'(y_s[2]) / 2) * 32 + int'(x_s[2]) / 2;
          last_wx = int'(x_s[2]);
          last_wy = int'(y_s[2]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int s, vc, dc, ec, guard;

  task automatic snap();
    vc = valid_cnt[0]; dc = done_cnt[0]; ec = err_cnt[0];
  endtask

  task automatic run_basic(input string nm);
    snap();
    s = cyc;
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (24) step();
    chk({nm, "_first_valid"}, 32'(rise_cyc[0] - s), 32'd3);
    chk({nm, "_done_cycle"}, 32'(done_cyc[0] - s), 32'd19);
    chk({nm, "_beats"}, 32'(valid_cnt[0] - vc), 32'd16);
    chk({nm, "_dones"}, 32'(done_cnt[0] - dc), 32'd1);
    chk({nm, "_errs"}, 32'(err_cnt[0] - ec), 32'd0);
  endtask

  initial begin
    rst0 = 1'b0; rst12 = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) step();
    chk("reset_busy", 32'(b0), 32'd0);
    chk("reset_addr", 32'(addr0), 32'd0);
    rst0 = 1'b1; rst12 = 1'b1;
    step(); step();

    // Basic 4x4 scan alongside the 1x1 and 64x64 configurations
    snap();
    s = cyc;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    step();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    chk("s1_addr_c1", 32'(addr0), 32'd0);
    repeat (24) step();
    chk("s1_first_valid", 32'(rise_cyc[0] - s), 32'd3);
    chk("s1_done_cycle", 32'(done_cyc[0] - s), 32'd19);
    chk("s1_beats", 32'(valid_cnt[0] - vc), 32'd16);
    chk("s1_dones", 32'(done_cnt[0] - dc), 32'd1);
    chk("one_first_valid", 32'(rise_cyc[1] - s), 32'd2);
    chk("one_done_cycle", 32'(done_cyc[1] - s), 32'd3);
    chk("one_beats", 32'(valid_cnt[1]), 32'd1);

    // Rejected start mid-scan
    snap();
    s = cyc;
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (7) step();
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (20) step();
    chk("s2_errs", 32'(err_cnt[0] - ec), 32'd1);
    chk("s2_done_cycle", 32'(done_cyc[0] - s), 32'd19);
    chk("s2_beats", 32'(valid_cnt[0] - vc), 32'd16);

    // Reset in cycle 10 of a scan, then a fresh scan
    snap();
    s = cyc;
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (9) step();
    rst0 = 1'b0;
    #1;
    chk("s3_rst_busy", 32'(b0), 32'd0);
    chk("s3_rst_valid", 32'(v0), 32'd0);
    chk("s3_rst_addr", 32'(addr0), 32'd0);
    step(); step();
    rst0 = 1'b1;
    repeat (20) step();
    chk("s3_no_done", 32'(done_cnt[0] - dc), 32'd0);
    run_basic("s3_rescan");

    // Back-to-back: second start in the DONE cycle
    snap();
    s = cyc;
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (18) step();
    chk("s5_done_now", 32'(dn0), 32'd1);
    start0 = 1'b1; step(); start0 = 1'b0;
    repeat (44) step();
    chk("s5_beats", 32'(valid_cnt[0] - vc), 32'd32);
    chk("s5_dones", 32'(done_cnt[0] - dc), 32'd2);
    chk("s5_errs", 32'(err_cnt[0] - ec), 32'd0);
    chk("s5_done2_cycle", 32'(done_cyc[0] - s), 32'd38);

    // 64x64 scan feeding a half-resolution writer
    guard = 0;
    while (done_cnt[2] == 0 && guard < 6000) begin
      step();
      guard++;
    end
    chk("big_done", 32'(done_cnt[2]), 32'd1);
    chk("big_beats", 32'(valid_cnt[2]), 32'd4096);
    chk("half_writes", 32'(wr_cnt), 32'd1024);
    chk("half_last_addr", 32'(last_wr_addr), 32'd1023);
    chk("half_last_x", 32'(last_wx), 32'd62);
    chk("half_last_y", 32'(last_wy), 32'd62);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
